// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA bar animation and colour stages.
package vga_pkg;

  localparam int BAR_POS_W = 9;
  localparam int BAR_VEL_W = 5;

  // Geometry consumed by the colour stage when drawing a bar around its offset.
  localparam int SCREEN_MID_LINE = 240;
  localparam int BAR_HALF_HEIGHT = 16;

  typedef enum logic {
    WAIT = 1'b0,
    MOVE = 1'b1
  } bar_state_t;

  // Symmetric clamp of a one-bit-widened velocity to +/-lim.
  function automatic logic signed [BAR_VEL_W:0] clamp_vel(
    input logic signed [BAR_VEL_W:0] v,
    input logic signed [BAR_VEL_W:0] lim
  );
    logic signed [BAR_VEL_W:0] r;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_tick_edge.sv
// Rising-edge detector for the frame strobe; emits one enable-qualified
// single-cycle event per strobe regardless of strobe width.
module frame_tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic enable,
  output logic tick_ev
);

  logic prev_tick_r;

  // Strobe history, cleared in reset so a strobe high at release counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_tick_r <= 1'b0;
    end else begin
      prev_tick_r <= tick;
    end
  end

  assign tick_ev = tick & ~prev_tick_r & enable;

endmodule

// File: rtl/vga_bar_motion.sv
// Per-bar animation engine: signed vertical offset of one bar relative to the
// screen mid-line, advanced once per frame by a bounded sign-force oscillation.
module vga_bar_motion
  import vga_pkg::*;
#(
  parameter int START_DELAY  = 0,
  parameter int AMPLITUDE    = 200,
  parameter int MAX_SPEED    = 8,
  parameter int ACCEL_PERIOD = 2
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic                        i_NewFrameTick,
  input  logic                        i_Enable,
  output logic signed [BAR_POS_W-1:0] o_VerticalSplitLine,
  output logic signed [BAR_VEL_W-1:0] o_Velocity,
  output logic                        o_Moving
);

  localparam logic [7:0]                  DELAY_LAST = 8'(START_DELAY);
  localparam logic [4:0]                  ACCEL_LAST = 5'(ACCEL_PERIOD - 1);
  localparam logic signed [BAR_VEL_W:0]   VEL_LIM    = 6'(MAX_SPEED);
  localparam logic signed [BAR_VEL_W-1:0] VEL_KICK   = 5'(MAX_SPEED);
  localparam logic signed [9:0]           AMP_POS    = 10'(AMPLITUDE);
  localparam logic signed [9:0]           AMP_NEG    = 10'(-AMPLITUDE);
  localparam logic signed [BAR_POS_W-1:0] OFS_POS    = 9'(AMPLITUDE);
  localparam logic signed [BAR_POS_W-1:0] OFS_NEG    = 9'(-AMPLITUDE);

  bar_state_t                  state_r;
  logic [7:0]                  delay_r;
  logic [4:0]                  accel_r;
  logic signed [BAR_POS_W-1:0] offset_r;
  logic signed [BAR_VEL_W-1:0] vel_r;
  logic                        moving_r;

  logic                        tick_ev_s;
  logic signed [BAR_VEL_W:0]   force_s;
  logic signed [BAR_VEL_W:0]   vel_next_s;
  logic [4:0]                  accel_next_s;
  logic signed [9:0]           sum_s;

  frame_tick_edge u_tick (
    .clk    (i_Clk),
    .rst    (i_Reset),
    .tick   (i_NewFrameTick),
    .enable (i_Enable),
    .tick_ev(tick_ev_s)
  );

  // Restoring force, periodic velocity step and the unbounded next position.
  always_comb begin
    force_s      = 6'sd0;
    vel_next_s   = {vel_r[BAR_VEL_W-1], vel_r};
    accel_next_s = accel_r;
    sum_s        = 10'sd0;

    if (offset_r > 9'sd0) begin
      force_s = -6'sd1;
    end else if (offset_r < 9'sd0) begin
      force_s = 6'sd1;
    end else begin
      force_s = 6'sd0;
    end

    if (accel_r == ACCEL_LAST) begin
      vel_next_s   = clamp_vel({vel_r[BAR_VEL_W-1], vel_r} + force_s, VEL_LIM);
      accel_next_s = 5'd0;
    end else begin
      vel_next_s   = {vel_r[BAR_VEL_W-1], vel_r};
      accel_next_s = accel_r + 5'd1;
    end

    // 10-bit sum cannot overflow: |offset| <= 255-MAX_SPEED, |v| <= 15.
    sum_s = {offset_r[BAR_POS_W-1], offset_r} + {{4{vel_next_s[BAR_VEL_W]}}, vel_next_s};
  end

  // WAIT/MOVE state machine; everything advances only on a qualified tick.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_r  <= WAIT;
      delay_r  <= 8'd0;
      accel_r  <= 5'd0;
      offset_r <= 9'sd0;
      vel_r    <= 5'sd0;
      moving_r <= 1'b0;
    end else if (tick_ev_s) begin
      case (state_r)
        WAIT: begin
          if (delay_r == DELAY_LAST) begin
            state_r  <= MOVE;
            vel_r    <= VEL_KICK;
            moving_r <= 1'b1;
            accel_r  <= 5'd0;
          end else begin
            delay_r <= delay_r + 8'd1;
          end
        end
        MOVE: begin
          accel_r <= accel_next_s;
          if (sum_s > AMP_POS) begin
            offset_r <= OFS_POS;
            vel_r    <= 5'sd0;
          end else if (sum_s < AMP_NEG) begin
            offset_r <= OFS_NEG;
            vel_r    <= 5'sd0;
          end else begin
            offset_r <= sum_s[BAR_POS_W-1:0];
            vel_r    <= vel_next_s[BAR_VEL_W-1:0];
          end
        end
        default: begin
          state_r <= WAIT;
        end
      endcase
    end
  end

  assign o_VerticalSplitLine = offset_r;
  assign o_Velocity          = vel_r;
  assign o_Moving            = moving_r;

endmodule

// File: tb/tb_vga_bar_motion.sv
// Directed bench for vga_bar_motion: three parameter sets driven in lockstep,
// expected values queued when a tick is driven and compared after the edge.
module tb_vga_bar_motion;

  logic clk;
  logic rst;
  logic tick;
  logic en;

  logic signed [8:0] pos_o [3];
  logic signed [4:0] vel_o [3];
  logic              mov_o [3];

  int errors = 0;
  int checks = 0;

  // Instance 0: defaults, 1: START_DELAY=15, 2: AMPLITUDE=20.
  int p_sd  [3] = '{0, 15, 0};
  int p_amp [3] = '{200, 200, 20};
  int p_ms  [3] = '{8, 8, 8};
  int p_ap  [3] = '{2, 2, 2};

  int m_state [3];
  int m_delay [3];
  int m_accel [3];
  int m_pos   [3];
  int m_vel   [3];
  int m_mov   [3];
  int ev_cnt;

  typedef struct {
    int inst;
    int pos;
    int vel;
    int mov;
  } exp_t;
  exp_t sbq[$];

  int tbl_pos0 [4] = '{0, 8, 15, 22};
  int tbl_vel0 [4] = '{8, 8, 7, 7};

  vga_bar_motion #(.START_DELAY(0)) dut0 (
    .i_Clk(clk), .i_Reset(rst), .i_NewFrameTick(tick), .i_Enable(en),
    .o_VerticalSplitLine(pos_o[0]), .o_Velocity(vel_o[0]), .o_Moving(mov_o[0])
  );
  vga_bar_motion #(.START_DELAY(15)) dut15 (
    .i_Clk(clk), .i_Reset(rst), .i_NewFrameTick(tick), .i_Enable(en),
    .o_VerticalSplitLine(pos_o[1]), .o_Velocity(vel_o[1]), .o_Moving(mov_o[1])
  );
  vga_bar_motion #(.AMPLITUDE(20)) dut20 (
    .i_Clk(clk), .i_Reset(rst), .i_NewFrameTick(tick), .i_Enable(en),
    .o_VerticalSplitLine(pos_o[2]), .o_Velocity(vel_o[2]), .o_Moving(mov_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_state[i] = 0; m_delay[i] = 0; m_accel[i] = 0;
      m_pos[i] = 0; m_vel[i] = 0; m_mov[i] = 0;
    end
    ev_cnt = 0;
  endtask

  task automatic model_step(input int i);
    int f;
    int v;
    int s;
    if (m_state[i] == 0) begin
      if (m_delay[i] == p_sd[i]) begin
        m_state[i] = 1; m_vel[i] = p_ms[i]; m_mov[i] = 1; m_accel[i] = 0;
      end else begin
        m_delay[i]++;
      end
    end else begin
      f = (m_pos[i] > 0) ? -1 : ((m_pos[i] < 0) ? 1 : 0);
      if (m_accel[i] == p_ap[i] - 1) begin
        v = m_vel[i] + f;
        if (v > p_ms[i]) v = p_ms[i];
        if (v < -p_ms[i]) v = -p_ms[i];
        m_accel[i] = 0;
      end else begin
        v = m_vel[i];
        m_accel[i]++;
      end
      s = m_pos[i] + v;
      if (s > p_amp[i]) begin
        m_pos[i] = p_amp[i]; m_vel[i] = 0;
      end else if (s < -p_amp[i]) begin
        m_pos[i] = -p_amp[i]; m_vel[i] = 0;
      end else begin
        m_pos[i] = s; m_vel[i] = v;
      end
    end
  endtask

  task automatic step_and_push();
    ev_cnt++;
    for (int i = 0; i < 3; i++) begin
      model_step(i);
      sbq.push_back('{i, m_pos[i], m_vel[i], m_mov[i]});
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (sbq.size() == 0) begin
        chk({tag, "_sbq_empty"}, 32'sd0, 32'sd1);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("%s_pos%0d", tag, e.inst), pos_o[e.inst], e.pos);
        chk($sformatf("%s_vel%0d", tag, e.inst), vel_o[e.inst], e.vel);
        chk($sformatf("%s_mov%0d", tag, e.inst), mov_o[e.inst], e.mov);
      end
    end
  endtask

  task automatic hold_check(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_pos%0d", tag, i), pos_o[i], m_pos[i]);
      chk($sformatf("%s_vel%0d", tag, i), vel_o[i], m_vel[i]);
      chk($sformatf("%s_mov%0d", tag, i), mov_o[i], m_mov[i]);
    end
  endtask

  // Called just after a rising clock edge; leaves the bench 1 time unit after an edge.
  task automatic drive_tick(input int width);
    bit ev;
    ev = (en === 1'b1) && (rst === 1'b0);
    tick = 1'b1;
    hold_check("pre_edge");
    if (ev) step_and_push();
    @(posedge clk); #1;
    if (ev) pop_check("tick"); else hold_check("disabled");
    for (int c = 1; c < width; c++) begin
      @(posedge clk); #1;
      hold_check("held");
    end
    tick = 1'b0;
    @(posedge clk); #1;
    hold_check("gap");
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; en = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    hold_check("reset");
    rst = 1'b0;

    for (int t = 0; t < 4; t++) begin
      drive_tick(1);
      chk($sformatf("seq0_pos_t%0d", t + 1), pos_o[0], tbl_pos0[t]);
      chk($sformatf("seq0_vel_t%0d", t + 1), vel_o[0], tbl_vel0[t]);
    end
    chk("amp20_t4_pos", pos_o[2], 32'sd20);
    chk("amp20_t4_vel", vel_o[2], 32'sd0);

    // Asynchronous reset mid-motion, observed before any clock edge.
    #2; rst = 1'b1; #1;
    model_reset();
    chk("async_rst_pos0", pos_o[0], 32'sd0);
    chk("async_rst_vel0", vel_o[0], 32'sd0);
    chk("async_rst_mov0", mov_o[0], 32'sd0);
    hold_check("async_rst");

    // Strobe already high at reset release, held for 10 cycles.
    tick = 1'b1;
    @(posedge clk); #1;
    hold_check("in_rst");
    rst = 1'b0;
    step_and_push();
    @(posedge clk); #1;
    pop_check("rel_tick");
    chk("rekick_vel0", vel_o[0], 32'sd8);
    chk("rekick_mov0", mov_o[0], 32'sd1);
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
      hold_check("rel_held");
    end
    tick = 1'b0;
    @(posedge clk); #1;
    hold_check("rel_gap");

    for (int t = 2; t <= 5; t++) begin
      drive_tick(1);
      if (t == 4) begin
        chk("amp20_sat_pos", pos_o[2], 32'sd20);
        chk("amp20_sat_vel", vel_o[2], 32'sd0);
      end
      if (t == 5) begin
        chk("amp20_t5_pos", pos_o[2], 32'sd19);
        chk("amp20_t5_vel", vel_o[2], -32'sd1);
      end
    end

    // Disabled ticks are lost; the sequence resumes as if they never happened.
    en = 1'b0;
    for (int t = 0; t < 3; t++) drive_tick(1);
    en = 1'b1;
    drive_tick(1);

    // Wide strobe while moving: exactly one update.
    drive_tick(10);

    while (ev_cnt < 16) begin
      drive_tick(1);
      if (ev_cnt < 16) begin
        chk($sformatf("delay15_wait_t%0d", ev_cnt), mov_o[1], 32'sd0);
      end else begin
        chk("delay15_kick_mov", mov_o[1], 32'sd1);
        chk("delay15_kick_vel", vel_o[1], 32'sd8);
        chk("delay15_kick_pos", pos_o[1], 32'sd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
